// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared types and constants for the shared binary-to-BCD converter.
package bcd_conv_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StConv = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bits per packed BCD digit.
  localparam int unsigned DigitW = 4;
  // Digits at or above this value get +3 before each shift.
  localparam int unsigned AddThresh = 5;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add-3 correction on every digit, then shift in
// the binary shift-register MSB.
module bcd_dabble_step
  import bcd_conv_arbiter_pkg::*;
#(
  parameter int unsigned NDIG = 3
) (
  input  logic [DigitW*NDIG-1:0] acc,
  input  logic                   msb,
  output logic [DigitW*NDIG-1:0] acc_next
);

  logic [DigitW*NDIG-1:0] corr;

  // Correct each digit that would overflow past 9 after doubling, then shift.
  always_comb begin
    corr = acc;
    for (int k = 0; k < int'(NDIG); k++) begin
      if (acc[k*DigitW +: DigitW] >= DigitW'(AddThresh)) begin
        corr[k*DigitW +: DigitW] = acc[k*DigitW +: DigitW] + 4'd3;
      end
    end
    acc_next = {corr[DigitW*NDIG-2:0], msb};
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one sequential binary-to-BCD converter between
// NREQ requesters.
module bcd_conv_arbiter
  import bcd_conv_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NDIG  = 3,
  localparam int unsigned IdW  = (NREQ > 1) ? clog2(NREQ) : 1,
  localparam int unsigned CntW = clog2(WIDTH + 1),
  localparam int unsigned BcdW = DigitW * NDIG
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ*WIDTH-1:0] Bin,
  output logic [NREQ-1:0]       Gnt,
  output logic                  Busy,
  output logic                  Done,
  output logic [IdW-1:0]        DoneId,
  output logic [BcdW-1:0]       Bcd
);

  state_e            state_q, state_d;
  logic [IdW-1:0]    ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [BcdW-1:0]   acc_q, acc_d, acc_step;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              done_q, done_d;
  logic [IdW-1:0]    done_id_q, done_id_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;

  logic              req_any;
  logic [IdW-1:0]    win;
  logic [IdW-1:0]    cand;
  logic              arb;
  logic              last_iter;

  bcd_dabble_step #(
    .NDIG(NDIG)
  ) u_step (
    .acc      (acc_q),
    .msb      (sh_q[WIDTH-1]),
    .acc_next (acc_step)
  );

  // Round-robin pick: first set Req bit searching upward from ptr_q + 1.
  always_comb begin
    win     = ptr_q;
    req_any = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IdW'((32'(ptr_q) + k) % NREQ);
      if (!req_any && Req[cand]) begin
        req_any = 1'b1;
        win     = cand;
      end
    end
  end

  assign arb       = (state_q != StConv) && req_any;
  assign last_iter = (cnt_q == CntW'(WIDTH - 1));

  // State register plus datapath and output registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= StIdle;
      ptr_q     <= IdW'(NREQ - 1);
      cnt_q     <= '0;
      sh_q      <= '0;
      acc_q     <= '0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      acc_q     <= acc_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      bcd_q     <= bcd_d;
    end
  end

  // Next state: arbitrate in IDLE/DONE, leave CONV after the last iteration.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: state_d = req_any ? StConv : StIdle;
      StConv:         if (last_iter) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // Datapath: capture the winner's value on grant, iterate while converting.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    sh_d  = sh_q;
    acc_d = acc_q;
    if (arb) begin
      ptr_d = win;
      cnt_d = '0;
      sh_d  = Bin[32'(win)*WIDTH +: WIDTH];
      acc_d = '0;
    end else if (state_q == StConv) begin
      cnt_d = cnt_q + 1'b1;
      sh_d  = sh_q << 1;
      acc_d = acc_step;
    end
  end

  // Registered outputs: grant pulse, done pulse, and held result.
  always_comb begin
    gnt_d     = arb ? (NREQ'(1) << win) : '0;
    done_d    = (state_q == StConv) && last_iter;
    bcd_d     = done_d ? acc_step : bcd_q;
    done_id_d = done_d ? ptr_q : done_id_q;
  end

  assign Gnt    = gnt_q;
  assign Busy   = (state_q != StIdle);
  assign Done   = done_q;
  assign DoneId = done_id_q;
  assign Bcd    = bcd_q;

endmodule
